// File: rtl/pipe_skid_reg.sv
// Ready/valid register stage with a one-entry skid buffer.
// in_ready is decoded from the state register only, which breaks the combinational ready chain.
//
// state | meaning
// EMPTY | no beat held, out_valid low
// BUSY  | one beat held in main
// FULL  | older beat in main, newer beat in skid, in_ready low
module pipe_skid_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;

  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL) && !rst;
  assign out_data  = main_q;
  assign occupancy = state;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q <= in_data;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            skid_q <= in_data;
            state  <= FULL;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain side can fire
          if (out_fire) begin
            main_q <= skid_q;
            state  <= BUSY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
